// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store controller between EX/MEM and a word-addressed data bus.
// Latency: accept at edge N, bus_req after N; bus_rdy in first REQ cycle -> done after N+2; +1 per wait cycle.
// Backpressure: busy holds the pipeline while in REQ; REQ holds all bus outputs until bus_rdy (or timeout).
//
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN -- abort an access after TO_CYC REQ cycles
// without bus_rdy and flag it on bus_err. Without the macro REQ waits indefinitely and bus_err is 0.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ex_en, ex_mem_op      request valid and operation (0 NOP, 1 LDW, 2 LDH, 3 LDHU, 4 LDB, 5 LDBU,
//                         6 STW, 7 STH, 8 STB, 9-15 NOP)
//   ex_out                byte address; ex_mem_wr_data store data
//   bus_req/addr/rw/wr_data/byte_en   bus request side (registered, stable while busy)
//   bus_rdy, bus_rd_data  bus completion and read data
//   out                   extended load result, held until the next completing load
//   done, miss_align, bus_err  single-cycle completion / misalignment / timeout pulses
//   busy                  high while an access is outstanding (state REQ)
module mem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int TO_W   = 8,
    parameter int TO_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_en,
    input  logic [3:0]        ex_mem_op,
    input  logic [ADDR_W-1:0] ex_out,
    input  logic [31:0]       ex_mem_wr_data,
    output logic              bus_req,
    output logic [ADDR_W-3:0] bus_addr,
    output logic              bus_rw,
    output logic [31:0]       bus_wr_data,
    output logic [3:0]        bus_byte_en,
    input  logic              bus_rdy,
    input  logic [31:0]       bus_rd_data,
    output logic [31:0]       out,
    output logic              done,
    output logic              miss_align,
    output logic              busy,
    output logic              bus_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [3:0] OP_LDW  = 4'd1;
    localparam logic [3:0] OP_LDH  = 4'd2;
    localparam logic [3:0] OP_LDHU = 4'd3;
    localparam logic [3:0] OP_LDB  = 4'd4;
    localparam logic [3:0] OP_LDBU = 4'd5;
    localparam logic [3:0] OP_STW  = 4'd6;
    localparam logic [3:0] OP_STH  = 4'd7;
    localparam logic [3:0] OP_STB  = 4'd8;

    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic [ADDR_W-3:0] bus_addr_q, bus_addr_d;
    logic              bus_rw_q, bus_rw_d;
    logic [31:0]       bus_wr_data_q, bus_wr_data_d;
    logic [3:0]        bus_byte_en_q, bus_byte_en_d;
    logic [31:0]       out_q, out_d;
    logic              done_q, done_d;
    logic              miss_align_q, miss_align_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    // Completion is seen on the bus_rdy edge but reported one cycle later.
    logic              cmp_pend_q, cmp_pend_d;

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Abort on the REQ cycle whose increment would bring the count to TO_CYC.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              err_pend_q, err_pend_d;
    logic              bus_err_q, bus_err_d;
`else
    logic [TO_W-1:0]   unused_to_cfg;
    assign unused_to_cfg = TO_W'(TO_CYC);
`endif

    // ------------------------------------------------------------------
    // Request decode: class, alignment and store lane steering
    // ------------------------------------------------------------------
    logic        req_is_ld;
    logic        req_is_st;
    logic        req_aligned;
    logic [1:0]  req_off;
    logic [31:0] st_data;
    logic [3:0]  st_be;

    always_comb begin
        req_off     = ex_out[1:0];
        req_is_ld   = 1'b0;
        req_is_st   = 1'b0;
        req_aligned = 1'b1;
        st_data     = ex_mem_wr_data;
        st_be       = 4'b1111;
        case (ex_mem_op)
            OP_LDW: begin
                req_is_ld   = 1'b1;
                req_aligned = (req_off == 2'd0);
            end
            OP_LDH, OP_LDHU: begin
                req_is_ld   = 1'b1;
                req_aligned = ~req_off[0];
            end
            OP_LDB, OP_LDBU: begin
                req_is_ld   = 1'b1;
            end
            OP_STW: begin
                req_is_st   = 1'b1;
                req_aligned = (req_off == 2'd0);
            end
            OP_STH: begin
                req_is_st   = 1'b1;
                req_aligned = ~req_off[0];
                st_data     = {2{ex_mem_wr_data[15:0]}};
                st_be       = req_off[1] ? 4'b1100 : 4'b0011;
            end
            OP_STB: begin
                req_is_st   = 1'b1;
                st_data     = {4{ex_mem_wr_data[7:0]}};
                st_be       = 4'b0001 << req_off;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load data lane select and extension, using the latched op/offset
    // ------------------------------------------------------------------
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;
    logic [31:0] ld_val;

    always_comb begin
        ld_half = off_q[1] ? bus_rd_data[31:16] : bus_rd_data[15:0];
        ld_byte = bus_rd_data[{off_q, 3'b000} +: 8];
        case (op_q)
            OP_LDW:  ld_val = bus_rd_data;
            OP_LDH:  ld_val = {{16{ld_half[15]}}, ld_half};
            OP_LDHU: ld_val = {16'h0000, ld_half};
            OP_LDB:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LDBU: ld_val = {24'h000000, ld_byte};
            // Stores keep the previous load result.
            default: ld_val = out_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_addr_d    = bus_addr_q;
        bus_rw_d      = bus_rw_q;
        bus_wr_data_d = bus_wr_data_q;
        bus_byte_en_d = bus_byte_en_q;
        out_d         = out_q;
        op_d          = op_q;
        off_d         = off_q;
        cmp_pend_d    = 1'b0;
        done_d        = cmp_pend_q;
        miss_align_d  = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        err_pend_d    = 1'b0;
        bus_err_d     = err_pend_q;
`endif

        case (state_q)
            IDLE: begin
                if (ex_en && (req_is_ld || req_is_st)) begin
                    if (!req_aligned) begin
                        // Rejected without touching the bus or out.
                        done_d       = 1'b1;
                        miss_align_d = 1'b1;
                    end else begin
                        bus_req_d     = 1'b1;
                        bus_addr_d    = ex_out[ADDR_W-1:2];
                        bus_rw_d      = req_is_ld;
                        bus_wr_data_d = req_is_st ? st_data : bus_wr_data_q;
                        bus_byte_en_d = req_is_st ? st_be : 4'b1111;
                        op_d          = ex_mem_op;
                        off_d         = req_off;
                        state_d       = REQ;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        to_cnt_d      = '0;
`endif
                    end
                end
            end

            REQ: begin
                if (bus_rdy) begin
                    bus_req_d  = 1'b0;
                    cmp_pend_d = 1'b1;
                    out_d      = ld_val;
                    state_d    = IDLE;
`ifdef MEM_ACCESS_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    bus_req_d  = 1'b0;
                    cmp_pend_d = 1'b1;
                    err_pend_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    to_cnt_d   = to_cnt_q + 1'b1;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            bus_req_q     <= 1'b0;
            bus_addr_q    <= '0;
            bus_rw_q      <= 1'b1;
            bus_wr_data_q <= '0;
            bus_byte_en_q <= '0;
            out_q         <= '0;
            done_q        <= 1'b0;
            miss_align_q  <= 1'b0;
            op_q          <= '0;
            off_q         <= '0;
            cmp_pend_q    <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            to_cnt_q      <= '0;
            err_pend_q    <= 1'b0;
            bus_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_addr_q    <= bus_addr_d;
            bus_rw_q      <= bus_rw_d;
            bus_wr_data_q <= bus_wr_data_d;
            bus_byte_en_q <= bus_byte_en_d;
            out_q         <= out_d;
            done_q        <= done_d;
            miss_align_q  <= miss_align_d;
            op_q          <= op_d;
            off_q         <= off_d;
            cmp_pend_q    <= cmp_pend_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            err_pend_q    <= err_pend_d;
            bus_err_q     <= bus_err_d;
`endif
        end
    end

    assign bus_req     = bus_req_q;
    assign bus_addr    = bus_addr_q;
    assign bus_rw      = bus_rw_q;
    assign bus_wr_data = bus_wr_data_q;
    assign bus_byte_en = bus_byte_en_q;
    assign out         = out_q;
    assign done        = done_q;
    assign miss_align  = miss_align_q;
    assign busy        = (state_q == REQ);
`ifdef MEM_ACCESS_TIMEOUT_EN
    assign bus_err     = bus_err_q;
`else
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scenario tasks for mem_access_ctrl with a scoreboard of expected completions.
// Latency: n/a (testbench).
// Backpressure: bench drives bus_rdy with a per-access wait count.
module tb_mem_access_ctrl;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDW  = 4'd1;
    localparam logic [3:0] OP_LDH  = 4'd2;
    localparam logic [3:0] OP_LDHU = 4'd3;
    localparam logic [3:0] OP_LDB  = 4'd4;
    localparam logic [3:0] OP_LDBU = 4'd5;
    localparam logic [3:0] OP_STW  = 4'd6;
    localparam logic [3:0] OP_STH  = 4'd7;
    localparam logic [3:0] OP_STB  = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_en;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_out;
    logic [31:0] ex_mem_wr_data;
    logic        bus_req;
    logic [29:0] bus_addr;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [3:0]  bus_byte_en;
    logic        bus_rdy;
    logic [31:0] bus_rd_data;
    logic [31:0] out;
    logic        done;
    logic        miss_align;
    logic        busy;
    logic        bus_err;

    mem_access_ctrl #(.ADDR_W(32), .TO_W(8), .TO_CYC(4)) dut (
        .clk(clk), .reset(reset), .ex_en(ex_en), .ex_mem_op(ex_mem_op), .ex_out(ex_out),
        .ex_mem_wr_data(ex_mem_wr_data), .bus_req(bus_req), .bus_addr(bus_addr), .bus_rw(bus_rw),
        .bus_wr_data(bus_wr_data), .bus_byte_en(bus_byte_en), .bus_rdy(bus_rdy),
        .bus_rd_data(bus_rd_data), .out(out), .done(done), .miss_align(miss_align),
        .busy(busy), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] out;
        logic        miss;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_out;
    logic [29:0] model_addr;

    // Observations of the last access
    int          busy_n, done_k, done_n;
    logic        req_seen, stable;
    logic [31:0] r_out;
    logic        r_miss, r_err;
    logic [29:0] s_addr;
    logic        s_rw;
    logic [31:0] s_wd;
    logic [3:0]  s_be;

    // Present one request for one cycle, then respond with bus_rdy after 'waits'
    // REQ cycles (negative: never). k counts edges after the accept edge N.
    task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits);
        int win;
        win = (waits < 0) ? 16 : waits + 8;
        @(negedge clk);
        ex_en = 1'b1; ex_mem_op = op; ex_out = addr; ex_mem_wr_data = wd; bus_rd_data = rd;
        @(posedge clk); #1;
        ex_en = 1'b0;
        busy_n = 0; done_k = -1; done_n = 0; req_seen = 1'b0; stable = 1'b1;
        r_out = '0; r_miss = 1'b0; r_err = 1'b0;
        for (int k = 0; k < win; k++) begin
            bus_rdy = (k == waits);
            @(negedge clk);
            if (busy) busy_n++;
            if (bus_req) req_seen = 1'b1;
            if (k == 0) begin
                s_addr = bus_addr; s_rw = bus_rw; s_wd = bus_wr_data; s_be = bus_byte_en;
            end else if (busy && ({bus_req, bus_addr, bus_rw, bus_wr_data, bus_byte_en} !==
                                  {1'b1, s_addr, s_rw, s_wd, s_be})) begin
                stable = 1'b0;
            end
            if (done) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k; r_out = out; r_miss = miss_align; r_err = bus_err;
                end
            end
            @(posedge clk); #1;
        end
        bus_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ex_en = 1'b0; ex_mem_op = OP_NOP; ex_out = '0; ex_mem_wr_data = '0;
        bus_rdy = 1'b0; bus_rd_data = '0;
        #1;
        n_tests++;
        if ({bus_req, bus_rw, bus_addr, bus_wr_data, bus_byte_en} !== {1'b0, 1'b1, 30'h0, 32'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_bus: got req=%b rw=%b addr=%h wd=%h be=%b want 0 1 0 0 0",
                     bus_req, bus_rw, bus_addr, bus_wr_data, bus_byte_en);
        end
        n_tests++;
        if ({out, done, miss_align, busy, bus_err} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_out: got out=%h done=%b miss=%b busy=%b err=%b want all 0",
                     out, done, miss_align, busy, bus_err);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_out = 32'h0; model_addr = 30'h0;
    endtask

    task automatic test_ldb();
        sb.push_back('{out: 32'hFFFF_FF80, miss: 1'b0, err: 1'b0});
        access(OP_LDB, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
        n_tests++;
        if ({s_addr, s_be, s_rw} !== {30'h400, 4'b1111, 1'b1}) begin
            n_fail++;
            $display("FAIL ldb_req: got addr=%h be=%b rw=%b want 400 1111 1", s_addr, s_be, s_rw);
        end
        n_tests++;
        if (done_k !== 2 || done_n !== 1) begin
            n_fail++;
            $display("FAIL ldb_latency: got done_k=%0d pulses=%0d want 2 1", done_k, done_n);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_tests++;
        if ({r_out, r_miss, r_err} !== {e.out, e.miss, e.err}) begin
            n_fail++;
            $display("FAIL ldb_out: got out=%h miss=%b err=%b want %h %b %b", r_out, r_miss, r_err, e.out, e.miss, e.err);
        end
        model_out = 32'hFFFF_FF80; model_addr = 30'h400;
    endtask

    task automatic test_loads();
        logic [3:0]  op [6];
        logic [31:0] ad [6];
        logic [31:0] rd [6];
        logic [31:0] ex [6];
        int          wt [6];
        logic [31:0] a;
        op = '{OP_LDW, OP_LDH, OP_LDH, OP_LDBU, OP_LDB, OP_LDB};
        ad = '{32'h10, 32'h2002, 32'h2000, 32'h1002, 32'h1001, 32'h1000};
        rd = '{32'hDEAD_BEEF, 32'h9ABC_5678, 32'h9ABC_5678, 32'h80FF_1234, 32'h80FF_1234, 32'h0000_00F0};
        ex = '{32'hDEAD_BEEF, 32'hFFFF_9ABC, 32'h0000_5678, 32'h0000_00FF, 32'h0000_0012, 32'hFFFF_FFF0};
        wt = '{1, 0, 0, 2, 0, 2};
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{out: ex[i], miss: 1'b0, err: 1'b0});
            access(op[i], ad[i], 32'h0, rd[i], wt[i]);
            a = ad[i];
            n_tests++;
            if (s_addr !== a[31:2] || done_k !== 2 + wt[i] || done_n !== 1) begin
                n_fail++;
                $display("FAIL load%0d_timing: got addr=%h done_k=%0d pulses=%0d want %h %0d 1",
                         i, s_addr, done_k, done_n, a[31:2], 2 + wt[i]);
            end
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            n_tests++;
            if ({r_out, r_miss} !== {e.out, e.miss}) begin
                n_fail++;
                $display("FAIL load%0d_out: got out=%h miss=%b want %h %b", i, r_out, r_miss, e.out, e.miss);
            end
            model_out = ex[i]; model_addr = a[31:2];
        end
    endtask

    task automatic test_ldhu_wait();
        sb.push_back('{out: 32'h0000_9ABC, miss: 1'b0, err: 1'b0});
        access(OP_LDHU, 32'h0000_2002, 32'h0, 32'h9ABC_5678, 3);
        n_tests++;
        if (busy_n !== 4 || done_n !== 1 || done_k !== 5 || stable !== 1'b1) begin
            n_fail++;
            $display("FAIL ldhu_wait: got busy=%0d pulses=%0d done_k=%0d stable=%b want 4 1 5 1",
                     busy_n, done_n, done_k, stable);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_tests++;
        if (r_out !== e.out) begin
            n_fail++;
            $display("FAIL ldhu_out: got %h want %h", r_out, e.out);
        end
        model_out = 32'h0000_9ABC; model_addr = 30'h800;
    endtask

    task automatic test_store();
        logic [3:0]  op [4];
        logic [31:0] ad [4];
        logic [31:0] dt [4];
        logic [31:0] xw [4];
        logic [3:0]  xb [4];
        int          wt [4];
        logic [31:0] a;
        op = '{OP_STB, OP_STH, OP_STH, OP_STW};
        ad = '{32'h1, 32'h22, 32'h20, 32'h44};
        dt = '{32'h1234_56AB, 32'h1234_BEEF, 32'h5555_0102, 32'hCAFE_F00D};
        xw = '{32'hABAB_ABAB, 32'hBEEF_BEEF, 32'h0102_0102, 32'hCAFE_F00D};
        xb = '{4'b0010, 4'b1100, 4'b0011, 4'b1111};
        wt = '{0, 1, 0, 2};
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{out: model_out, miss: 1'b0, err: 1'b0});
            access(op[i], ad[i], dt[i], 32'h7777_7777, wt[i]);
            a = ad[i];
            n_tests++;
            if ({s_rw, s_be, s_wd, s_addr} !== {1'b0, xb[i], xw[i], a[31:2]} || stable !== 1'b1) begin
                n_fail++;
                $display("FAIL store%0d_bus: got rw=%b be=%b wd=%h addr=%h stable=%b want 0 %b %h %h 1",
                         i, s_rw, s_be, s_wd, s_addr, stable, xb[i], xw[i], a[31:2]);
            end
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            n_tests++;
            if ({r_out, done_k, done_n} !== {e.out, 2 + wt[i], 1}) begin
                n_fail++;
                $display("FAIL store%0d_done: got out=%h done_k=%0d pulses=%0d want %h %0d 1",
                         i, r_out, done_k, done_n, e.out, 2 + wt[i]);
            end
            model_addr = a[31:2];
        end
    endtask

    task automatic test_misalign();
        logic [3:0]  op [4];
        logic [31:0] ad [4];
        op = '{OP_LDW, OP_STW, OP_LDH, OP_STH};
        ad = '{32'h6, 32'h2, 32'h1, 32'h3};
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{out: model_out, miss: 1'b1, err: 1'b0});
            access(op[i], ad[i], 32'h1111_2222, 32'h3333_4444, 0);
            n_tests++;
            if (done_k !== 0 || done_n !== 1 || req_seen !== 1'b0 || busy_n !== 0 || s_addr !== model_addr) begin
                n_fail++;
                $display("FAIL misalign%0d_ctl: got done_k=%0d pulses=%0d req=%b busy=%0d addr=%h want 0 1 0 0 %h",
                         i, done_k, done_n, req_seen, busy_n, s_addr, model_addr);
            end
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            n_tests++;
            if ({r_out, r_miss} !== {e.out, e.miss}) begin
                n_fail++;
                $display("FAIL misalign%0d_out: got out=%h miss=%b want %h %b", i, r_out, r_miss, e.out, e.miss);
            end
        end
    endtask

    task automatic test_nop();
        logic [3:0] op [3];
        op = '{OP_NOP, 4'd9, 4'd15};
        for (int i = 0; i < 3; i++) begin
            access(op[i], 32'h40, 32'h0, 32'h0, 0);
            n_tests++;
            if (done_n !== 0 || busy_n !== 0 || req_seen !== 1'b0) begin
                n_fail++;
                $display("FAIL nop%0d: got pulses=%0d busy=%0d req=%b want 0 0 0", i, done_n, busy_n, req_seen);
            end
        end
    endtask

    task automatic test_reset_mid();
        int dseen;
        @(negedge clk);
        ex_en = 1'b1; ex_mem_op = OP_LDW; ex_out = 32'h80; bus_rdy = 1'b0;
        @(posedge clk); #1;
        ex_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, bus_req} !== 2'b11) begin
            n_fail++;
            $display("FAIL rstmid_pre: got busy=%b req=%b want 1 1", busy, bus_req);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({bus_req, busy, done, out} !== {3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL rstmid_async: got req=%b busy=%b done=%b out=%h want 0 0 0 0", bus_req, busy, done, out);
        end
        @(negedge clk);
        reset = 1'b0;
        model_out = 32'h0; model_addr = 30'h0;
        dseen = 0;
        bus_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || bus_req) dseen++;
        end
        bus_rdy = 1'b0;
        n_tests++;
        if (dseen !== 0) begin
            n_fail++;
            $display("FAIL rstmid_nodone: got %0d done/req cycles want 0", dseen);
        end
        sb.push_back('{out: 32'h1122_3344, miss: 1'b0, err: 1'b0});
        access(OP_LDW, 32'h80, 32'h0, 32'h1122_3344, 0);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_tests++;
        if ({r_out, done_k, done_n} !== {e.out, 2, 1}) begin
            n_fail++;
            $display("FAIL rstmid_after: got out=%h done_k=%0d pulses=%0d want %h 2 1", r_out, done_k, done_n, e.out);
        end
        model_out = 32'h1122_3344; model_addr = 30'h20;
    endtask

    task automatic test_back_to_back();
        int dk;
        sb.push_back('{out: 32'h0F0E_0D0C, miss: 1'b0, err: 1'b0});
        sb.push_back('{out: 32'h0000_005A, miss: 1'b0, err: 1'b0});
        @(negedge clk);
        ex_en = 1'b1; ex_mem_op = OP_LDW; ex_out = 32'h100; bus_rd_data = 32'h0F0E_0D0C;
        @(posedge clk); #1;
        ex_en = 1'b0; bus_rdy = 1'b1;
        @(posedge clk); #1;
        bus_rdy = 1'b0;
        @(posedge clk); #1;
        // first access's done cycle: present the next request now
        ex_en = 1'b1; ex_mem_op = OP_LDBU; ex_out = 32'h105; bus_rd_data = 32'hA5A5_5AA5;
        @(negedge clk);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_tests++;
        if ({done, out} !== {1'b1, e.out}) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b out=%h want 1 %h", done, out, e.out);
        end
        @(posedge clk); #1;
        ex_en = 1'b0; bus_rdy = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus_req, busy, bus_addr, done} !== {2'b11, 30'h41, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_accept: got req=%b busy=%b addr=%h done=%b want 1 1 41 0", bus_req, busy, bus_addr, done);
        end
        @(posedge clk); #1;
        bus_rdy = 1'b0;
        dk = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done && dk < 0) begin dk = k; r_out = out; end
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_tests++;
        if (dk !== 1 || r_out !== e.out) begin
            n_fail++;
            $display("FAIL b2b_second: got done_at=%0d out=%h want 1 %h", dk, r_out, e.out);
        end
        model_out = 32'h0000_005A; model_addr = 30'h41;
    endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
    task automatic test_timeout();
        sb.push_back('{out: model_out, miss: 1'b0, err: 1'b1});
        access(OP_LDW, 32'h200, 32'h0, 32'h0BAD_F00D, -1);
        n_tests++;
        if (busy_n !== 4 || done_n !== 1 || done_k !== 5) begin
            n_fail++;
            $display("FAIL timeout_ctl: got busy=%0d pulses=%0d done_k=%0d want 4 1 5", busy_n, done_n, done_k);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_tests++;
        if ({r_out, r_miss, r_err} !== {e.out, e.miss, e.err}) begin
            n_fail++;
            $display("FAIL timeout_out: got out=%h miss=%b err=%b want %h 0 1", r_out, r_miss, r_err, e.out);
        end
    endtask
`else
    task automatic test_timeout();
        sb.push_back('{out: 32'h0BAD_F00D, miss: 1'b0, err: 1'b0});
        access(OP_LDW, 32'h200, 32'h0, 32'h0BAD_F00D, 12);
        n_tests++;
        if (busy_n !== 13 || done_n !== 1 || done_k !== 14) begin
            n_fail++;
            $display("FAIL longwait_ctl: got busy=%0d pulses=%0d done_k=%0d want 13 1 14", busy_n, done_n, done_k);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_tests++;
        if ({r_out, r_err} !== {e.out, e.err}) begin
            n_fail++;
            $display("FAIL longwait_out: got out=%h err=%b want %h 0", r_out, r_err, e.out);
        end
        model_out = 32'h0BAD_F00D;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ldb();
        test_loads();
        test_ldhu_wait();
        test_store();
        test_misalign();
        test_nop();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        n_tests++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequential MEM-stage controller between the EX/MEM pipeline register and the word-addressed data bus.
- Decodes word, halfword and byte loads and stores, and checks alignment before any bus access.
- Drives a request/ready bus handshake, then sign- or zero-extends load data.
- Raises busy so the pipeline stalls while an access is outstanding.

Parameters:
- ADDR_W, 32, width of the byte address from EX; the bus address is ADDR_W-2 bits.
- TO_W, 8, timeout counter width (used only with MEM_ACCESS_TIMEOUT_EN).
- TO_CYC, 255, cycles in REQ without bus_rdy before abort (used only with MEM_ACCESS_TIMEOUT_EN; must be < 2^TO_W).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ex_en  in  1  EX stage valid
- ex_mem_op  in  4  0 NOP, 1 LDW, 2 LDH, 3 LDHU, 4 LDB, 5 LDBU, 6 STW, 7 STH, 8 STB; 9-15 are treated as NOP
- ex_out  in  ADDR_W  byte address (ALU result)
- ex_mem_wr_data  in  32  store data (low bits used for STH/STB)
- bus_req  out  1  bus request
- bus_addr  out  ADDR_W-2  word address
- bus_rw  out  1  1 = read, 0 = write
- bus_wr_data  out  32  lane-replicated store data
- bus_byte_en  out  4  byte lane enables, bit i = byte i (little-endian)
- bus_rdy  in  1  bus completes the access this cycle
- bus_rd_data  in  32  read data, valid when bus_rdy=1
- out  out  32  extended load result
- done  out  1  one-cycle completion pulse
- miss_align  out  1  one-cycle misalignment pulse, coincident with done
- busy  out  1  stall request; high in REQ
- bus_err  out  1  one-cycle timeout pulse, coincident with done

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access): state = IDLE; bus_req = 0; bus_rw = 1; bus_addr = 0; bus_wr_data = 0; bus_byte_en = 0; out = 0; done = 0; miss_align = 0; bus_err = 0; busy = 0. Any in-flight access is dropped with no done pulse.
- All outputs are registered, except busy = (state == REQ).
- States: IDLE and REQ.
- IDLE accepts a request when ex_en = 1 and the op is not NOP. off = ex_out[1:0].
- Alignment rules:
  - LDW/STW require off == 0.
  - LDH/LDHU/STH require off[0] == 0.
  - Byte ops are always aligned.
- Misaligned request: next cycle done = 1 and miss_align = 1; out and all bus outputs unchanged; stay in IDLE; no bus access.
- Aligned request, registered at the next edge:
  - bus_req = 1, bus_addr = ex_out[ADDR_W-1:2].
  - bus_rw = 1 for loads, 0 for stores.
  - Latch op and off internally.
  - Go to REQ.
- Store lanes:
  - STW: wr_data = data; byte_en = 1111.
  - STH: wr_data = {2{data[15:0]}}; byte_en = 0011 if off = 0, 1100 if off = 2.
  - STB: wr_data = {4{data[7:0]}}; byte_en = 0001 << off.
  - Loads: byte_en = 1111.
- REQ: hold all bus outputs stable until bus_rdy = 1. On the edge where bus_rdy = 1:
  - bus_req = 0; done = 1 next cycle; return to IDLE.
  - Loads update out from bus_rd_data. Selected halfword = bits [16*off[1]+:16]; selected byte = bits [8*off+:8].
  - LDW passes the word; LDH/LDB sign-extend; LDHU/LDBU zero-extend.
  - Stores leave out unchanged.
- Latency: accept at edge N; bus_req high after N. If bus_rdy is high in the first REQ cycle, done is high after edge N+2. Each wait cycle adds one.
- out holds its value until the next completing load.
- done/miss_align/bus_err are single-cycle pulses.
- A new request is accepted in the same cycle done is high (state is IDLE), so back-to-back accesses are allowed.
- Requests with ex_en = 1 while in REQ are ignored. Upstream holds ex_* stable while busy = 1.
- bus_rdy is ignored in IDLE.

Optional Feature:
- MEM_ACCESS_TIMEOUT_EN defined:
  - A TO_W-bit counter clears on entering REQ and increments each REQ cycle without bus_rdy.
  - When the count reaches TO_CYC with bus_rdy still 0: bus_req = 0; done = 1 and bus_err = 1 next cycle; out unchanged; return to IDLE.
  - bus_rdy in the same cycle as the limit wins; the access completes normally.
- Undefined: no counter; REQ waits indefinitely; bus_err is tied to 0.

Test Plan:
- LDB, ex_out = 0x1003, bus_rd_data = 0x80FF_1234, bus_rdy in the first REQ cycle -> bus_addr = 0x400, byte_en = 1111, out = 0xFFFF_FF80, done 2 cycles after accept.
- LDHU, ex_out = 0x2002, bus_rd_data = 0x9ABC_5678, 3 wait cycles -> busy high 4 cycles, out = 0x0000_9ABC, single done pulse.
- STB, ex_out = 0x0001, data = 0x1234_56AB -> bus_rw = 0, byte_en = 0010, bus_wr_data = 0xABAB_ABAB, out unchanged.
- LDW, ex_out = 0x0006 -> miss_align = 1 and done = 1 one cycle later; bus_req never asserted.
- Reset asserted while in REQ -> bus_req = 0 immediately, no done pulse; next LDW completes normally.
- With MEM_ACCESS_TIMEOUT_EN, TO_CYC = 4, bus_rdy held 0 -> bus_req drops after 4 REQ cycles, bus_err = done = 1 for one cycle, out unchanged.
